data_mem_responder: RTL and testbench

Memory-side responder for the core's load/store port: accepts one request at a time over a valid/ready handshake and applies byte/half/word write strobes. It returns sign- or zero-extended read data after a programmable number of wait states. It sits between the execute stage's data-memory interface and the on-chip data RAM, and replaces the zero-latency data memory so the core can be exercised against realistic memory latency.

---
 rtl/dmem_pkg.sv | 62 ++++++
 rtl/dmem_array.sv | 28 ++
 rtl/data_mem_responder.sv | 125 ++++++++++++
 tb/tb_data_mem_responder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access sizes, FSM states,
// alignment checking and load-lane extraction.
package dmem_pkg;

    // Access size, same encoding as the execute stage's type_control
    typedef enum logic [1:0] {
        WORD = 2'b00,
        HALF = 2'b01,
        BYTE = 2'b10
    } access_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // Misaligned half/word, or the reserved type 2'b11
    function automatic logic is_misaligned(input logic [1:0] typ, input logic [1:0] off);
        case (typ)
            WORD:    return off != 2'b00;
            HALF:    return off[0];
            BYTE:    return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    // Little-endian byte enables for a store of the given size
    function automatic logic [3:0] byte_enables(input logic [1:0] typ, input logic [1:0] off);
        case (typ)
            WORD:    return 4'b1111;
            HALF:    return off[1] ? 4'b1100 : 4'b0011;
            BYTE:    return 4'b0001 << off;
            default: return 4'b0000;
        endcase
    endfunction

    // Replicate right-aligned store data across every lane it could land in
    function automatic logic [31:0] lane_replicate(input logic [1:0] typ, input logic [31:0] wdata);
        case (typ)
            HALF:    return {2{wdata[15:0]}};
            BYTE:    return {4{wdata[7:0]}};
            default: return wdata;
        endcase
    endfunction

    // Pick the addressed lane out of a RAM word and sign- or zero-extend it
    function automatic logic [31:0] extract_lane(input logic [31:0] word, input logic [1:0] off,
                                                 input logic [1:0] typ, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (typ)
            WORD:    return word;
            HALF:    return {{16{sgn & h[15]}}, h};
            BYTE:    return {{24{sgn & b[7]}}, b};
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Data RAM: word-organised, per-byte write enables, synchronous write and
// combinational read through a single shared index.
module dmem_array #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned INDEX_WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [3:0]             be,
    input  logic [INDEX_WIDTH-1:0] index,
    input  logic [DATA_WIDTH-1:0]  wdata,
    output logic [DATA_WIDTH-1:0]  rdata
);

    logic [DATA_WIDTH-1:0] mem [2**INDEX_WIDTH];

    // Byte-lane write; contents are deliberately left unreset
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (we && be[i]) begin
                mem[index][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[index];

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder: one outstanding request, stores commit on acceptance,
// response (extended load data or error) presented after LATENCY cycles.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [1:0]            req_type,
    input  logic                  req_sign,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err
);

    state_t                state, state_next;
    logic [3:0]            cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [1:0]            type_q;
    logic                  sign_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;

    logic                  accept;
    logic                  enter_resp;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [1:0]            cur_type;
    logic                  cur_sign;
    logic                  cur_write;
    logic                  cur_err;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic [DATA_WIDTH-1:0] resp_d;

    assign accept = (state == IDLE) && req_valid;

    // In IDLE the live request drives the RAM and response path so that
    // LATENCY==1 can form its response on the acceptance edge; afterwards
    // the latched copy takes over.
    assign cur_addr  = (state == IDLE) ? req_addr[ADDR_WIDTH-1:0] : addr_q;
    assign cur_type  = (state == IDLE) ? req_type  : type_q;
    assign cur_sign  = (state == IDLE) ? req_sign  : sign_q;
    assign cur_write = (state == IDLE) ? req_write : write_q;
    assign cur_err   = is_misaligned(cur_type, cur_addr[1:0]);
    assign ram_we    = accept && req_write && !cur_err;
    assign resp_d    = (cur_write || cur_err) ? '0
                     : extract_lane(ram_rdata, cur_addr[1:0], cur_type, cur_sign);

    dmem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .INDEX_WIDTH(ADDR_WIDTH - 2)
    ) u_array (
        .clk  (clk),
        .we   (ram_we),
        .be   (byte_enables(req_type, req_addr[1:0])),
        .index(cur_addr[ADDR_WIDTH-1:2]),
        .wdata(lane_replicate(req_type, req_wdata)),
        .rdata(ram_rdata)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = (LATENCY == 1) ? RESP : WAIT;
            WAIT:    if (cnt == 4'd0) state_next = RESP;
            RESP:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign enter_resp = (state_next == RESP) && (state != RESP);

    // Request latch, wait counter and registered response
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            type_q  <= '0;
            sign_q  <= 1'b0;
            write_q <= 1'b0;
            cnt     <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= req_addr[ADDR_WIDTH-1:0];
                type_q  <= req_type;
                sign_q  <= req_sign;
                write_q <= req_write;
                cnt     <= 4'(LATENCY - 1);
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_resp) begin
                rdata_q <= resp_d;
                err_q   <= cur_err;
            end else if (state == RESP && resp_ready) begin
                rdata_q <= '0;
                err_q   <= 1'b0;
            end
        end
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder at LATENCY=2: table of transactions
// plus hand-written backpressure and reset-abort sequences.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [1:0]  req_type = 2'b00;
    logic        req_sign = 1'b0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    data_mem_responder #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(12),
        .LATENCY   (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_type  (req_type),
        .req_sign  (req_sign),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err)
    );

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [1:0]  t;
        logic        s;
        logic [31:0] wd;
        logic [31:0] er;
        logic        ee;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_req(input logic w, input logic [31:0] a, input logic [1:0] t,
                             input logic s, input logic [31:0] wd);
        req_write = w;
        req_addr  = a;
        req_type  = t;
        req_sign  = s;
        req_wdata = wd;
        req_valid = 1'b1;
    endtask

    // One full transaction with resp_ready held high, checking cycle timing
    task automatic run_txn(input logic w, input logic [31:0] a, input logic [1:0] t,
                           input logic s, input logic [31:0] wd,
                           input logic [31:0] er, input logic ee, input string tag);
        @(negedge clk);
        chk({tag, " idle req_ready"}, 32'(req_ready), 32'd1);
        drive_req(w, a, t, s, wd);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk({tag, " busy req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, " resp_valid T+0"}, 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        chk({tag, " resp_valid T+1"}, 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        chk({tag, " resp_valid T+2"}, 32'(resp_valid), 32'd1);
        chk({tag, " resp_rdata"}, resp_rdata, er);
        chk({tag, " resp_err"}, 32'(resp_err), 32'(ee));
        @(posedge clk); #1;
        chk({tag, " resp_valid drop"}, 32'(resp_valid), 32'd0);
        chk({tag, " resp_rdata clear"}, resp_rdata, 32'd0);
    endtask

    // Accept a request, assert reset during WAIT, confirm the response is dropped
    task automatic reset_mid(input logic w, input logic [31:0] a, input logic [31:0] wd,
                             input string tag);
        @(negedge clk);
        drive_req(w, a, 2'b00, 1'b0, wd);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk({tag, " in WAIT req_ready"}, 32'(req_ready), 32'd0);
        #2 rst = 1'b0;
        #1;
        chk({tag, " reset req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, " reset resp_valid"}, 32'(resp_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk({tag, " no resp after reset"}, 32'(resp_valid), 32'd0);
        end
    endtask

    initial begin
        vecs[0]  = '{1'b1, 32'h010,  2'b00, 1'b0, 32'hDEADBEEF, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b0, 32'h010,  2'b00, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 32'h013,  2'b10, 1'b0, 32'hFFFFFF80, 32'h00000000, 1'b0};
        vecs[3]  = '{1'b0, 32'h013,  2'b10, 1'b1, 32'h0,        32'hFFFFFF80, 1'b0};
        vecs[4]  = '{1'b0, 32'h013,  2'b10, 1'b0, 32'h0,        32'h00000080, 1'b0};
        vecs[5]  = '{1'b0, 32'h010,  2'b00, 1'b0, 32'h0,        32'h80ADBEEF, 1'b0};
        vecs[6]  = '{1'b1, 32'h020,  2'b00, 1'b0, 32'h12345678, 32'h00000000, 1'b0};
        vecs[7]  = '{1'b1, 32'h022,  2'b01, 1'b0, 32'h0000BEEF, 32'h00000000, 1'b0};
        vecs[8]  = '{1'b0, 32'h022,  2'b01, 1'b0, 32'h0,        32'h0000BEEF, 1'b0};
        vecs[9]  = '{1'b0, 32'h020,  2'b00, 1'b0, 32'h0,        32'hBEEF5678, 1'b0};
        vecs[10] = '{1'b1, 32'h011,  2'b00, 1'b0, 32'h55555555, 32'h00000000, 1'b1};
        vecs[11] = '{1'b0, 32'h010,  2'b00, 1'b0, 32'h0,        32'h80ADBEEF, 1'b0};
        vecs[12] = '{1'b0, 32'h011,  2'b01, 1'b1, 32'h0,        32'h00000000, 1'b1};
        vecs[13] = '{1'b0, 32'h010,  2'b11, 1'b0, 32'h0,        32'h00000000, 1'b1};
        vecs[14] = '{1'b0, 32'h012,  2'b01, 1'b1, 32'h0,        32'hFFFF80AD, 1'b0};
        vecs[15] = '{1'b0, 32'h011,  2'b10, 1'b1, 32'h0,        32'hFFFFFFBE, 1'b0};
        vecs[16] = '{1'b0, 32'h1010, 2'b00, 1'b0, 32'h0,        32'h80ADBEEF, 1'b0};
        vecs[17] = '{1'b1, 32'h021,  2'b10, 1'b0, 32'h000000C3, 32'h00000000, 1'b0};
        vecs[18] = '{1'b0, 32'h020,  2'b00, 1'b0, 32'h0,        32'hBEEFC378, 1'b0};
        vecs[19] = '{1'b0, 32'h020,  2'b01, 1'b1, 32'h0,        32'hFFFFC378, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset resp_valid", 32'(resp_valid), 32'd0);
        chk("reset resp_rdata", resp_rdata, 32'd0);
        chk("reset resp_err", 32'(resp_err), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 20; i++) begin
            run_txn(vecs[i].w, vecs[i].a, vecs[i].t, vecs[i].s, vecs[i].wd,
                    vecs[i].er, vecs[i].ee, $sformatf("v%0d", i));
        end

        // Backpressure, with a second request held on req_valid throughout
        @(negedge clk);
        resp_ready = 1'b0;
        drive_req(1'b0, 32'h010, 2'b00, 1'b0, 32'h0);
        @(posedge clk); #1;
        drive_req(1'b0, 32'h013, 2'b10, 1'b1, 32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("bp enter resp_valid", 32'(resp_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk($sformatf("bp hold%0d resp_valid", i), 32'(resp_valid), 32'd1);
            chk($sformatf("bp hold%0d resp_rdata", i), resp_rdata, 32'h80ADBEEF);
            chk($sformatf("bp hold%0d resp_err", i), 32'(resp_err), 32'd0);
            chk($sformatf("bp hold%0d req_ready", i), 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp release resp_valid", 32'(resp_valid), 32'd0);
        chk("bp release req_ready", 32'(req_ready), 32'd1);
        chk("bp release resp_rdata", resp_rdata, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("bp second accept req_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        chk("bp second T+1 resp_valid", 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        chk("bp second resp_valid", 32'(resp_valid), 32'd1);
        chk("bp second resp_rdata", resp_rdata, 32'hFFFFFF80);
        @(posedge clk); #1;
        chk("bp second drop", 32'(resp_valid), 32'd0);

        // Reset mid-load, then a normal load
        reset_mid(1'b0, 32'h010, 32'h0, "rst load");
        run_txn(1'b0, 32'h010, 2'b00, 1'b0, 32'h0, 32'h80ADBEEF, 1'b0, "post rst load");

        // Reset during a store's wait: the store remains committed
        reset_mid(1'b1, 32'h030, 32'hCAFEF00D, "rst store");
        run_txn(1'b0, 32'h030, 2'b00, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0, "post rst store");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute guard so the run always ends
    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: got running expected finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
